// File: rtl/digit_serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor:
//   - FSM state encoding (IDLE, RUN, DONE)
//   - digit-count derivation from WIDTH and DIGIT
//   - a ceiling-log2 helper used to size the digit counter
package digit_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r such that 2**r >= v (v >= 1). Returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Number of DIGIT-bit slices needed to cover a WIDTH-bit operand.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_serial_subtractor_sub_digit.sv
// sub_digit: combinational DIGIT-bit borrow-ripple subtractor slice.
// Ports:
//   a    [DIGIT-1:0]  minuend slice
//   b    [DIGIT-1:0]  subtrahend slice
//   bin               borrow into the least significant bit
//   d    [DIGIT-1:0]  slice difference (a - b - bin, modulo 2**DIGIT)
//   bout              borrow out of the most significant bit
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] borrow;

  assign borrow[0] = bin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    // Full-subtractor cell: borrow when a < b, or a == b with a borrow pending.
    assign d[gi]          = a[gi] ^ b[gi] ^ borrow[gi];
    assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
  end

  assign bout = borrow[DIGIT];

endmodule

// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor: computes d = a - b - bin, DIGIT bits per clock,
// carrying the borrow between cycles in a register.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   in_valid / in_ready      operand handshake (a, b, bin sampled on accept)
//   a, b  [WIDTH-1:0]        minuend / subtrahend
//   bin                      borrow-in
//   out_valid / out_ready    result handshake
//   d     [WIDTH-1:0]        difference
//   bout                     unsigned borrow-out (a < b + bin)
//   ovf                      two's-complement overflow
//   zero                     d == 0
module digit_serial_subtractor
  import digit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int CNT_W      = clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             a_msb;
  logic             b_msb;

  logic [DIGIT-1:0] slice_d;
  logic             slice_bout;
  logic [WIDTH-1:0] res_next;
  logic             accept;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  // One slice, reused every RUN cycle on the low digit of the shift registers.
  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .bin  (borrow),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // Digits enter at the top, so after NUM_DIGITS shifts digit 0 sits at the LSB.
  assign res_next = {slice_d, res[WIDTH-1:DIGIT]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      borrow    <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res    <= res_next;
          borrow <= slice_bout;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_DIGIT) begin
            state     <= DONE;
            out_valid <= 1'b1;
            d         <= res_next;
            bout      <= slice_bout;
            // Overflow uses the original operand signs; bin does not enter the rule.
            ovf       <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
            zero      <= (res_next == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Accept overrides the DONE->IDLE move, giving back-to-back operation.
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
        borrow <= bin;
        cnt    <= '0;
        res    <= '0;
        state  <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
module tb_digit_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;

  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  bout;
  logic [2:0]  ovf;
  logic [2:0]  zero;
  logic [15:0] d_o [3];

  int checks;
  int errors;

  // Instance 0: DIGIT=4, instance 1: DIGIT=1, instance 2: DIGIT=8.
  localparam int LAT [3] = '{4, 16, 2};

  digit_serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid[0]), .out_ready(out_ready),
    .d(d_o[0]), .bout(bout[0]), .ovf(ovf[0]), .zero(zero[0])
  );

  digit_serial_subtractor #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid[1]), .out_ready(out_ready),
    .d(d_o[1]), .bout(bout[1]), .ovf(ovf[1]), .zero(zero[1])
  );

  digit_serial_subtractor #(.WIDTH(16), .DIGIT(8)) dut_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid[2]), .out_ready(out_ready),
    .d(d_o[2]), .bout(bout[2]), .ovf(ovf[2]), .zero(zero[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Apply one operand set to all three instances and check each at its own latency.
  task automatic run_vec(input vec_t v, input int idx);
    bit          seen [3];
    int          lat  [3];
    logic [15:0] cd   [3];
    logic [2:0]  cb, co, cz;
    cb = '0; co = '0; cz = '0;
    for (int k = 0; k < 3; k++) begin
      seen[k] = 1'b0; lat[k] = 0; cd[k] = '0;
    end
    out_ready = 1'b1;
    a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1;
    chk($sformatf("v%0d in_ready", idx), {29'd0, in_ready}, 32'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;   // operands must not matter after accept
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && out_valid[k]) begin
          seen[k] = 1'b1; lat[k] = cyc; cd[k] = d_o[k];
          cb[k] = bout[k]; co[k] = ovf[k]; cz[k] = zero[k];
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("v%0d dut%0d latency", idx, k), lat[k], LAT[k]);
      chk($sformatf("v%0d dut%0d d", idx, k), {16'd0, cd[k]}, {16'd0, v.d});
      chk($sformatf("v%0d dut%0d bout", idx, k), {31'd0, cb[k]}, {31'd0, v.bout});
      chk($sformatf("v%0d dut%0d ovf", idx, k), {31'd0, co[k]}, {31'd0, v.ovf});
      chk($sformatf("v%0d dut%0d zero", idx, k), {31'd0, cz[k]}, {31'd0, v.zero});
    end
    $display("vec %0d: %h - %h - %0d -> d=%h/%h/%h bout=%b ovf=%b zero=%b",
             idx, v.a, v.b, v.bin, cd[0], cd[1], cd[2], cb, co, cz);
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {29'd0, out_valid}, 32'd0);
    chk("reset d", {16'd0, d_o[0]}, 32'd0);
    chk("reset flags", {29'd0, bout | ovf | zero}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready after reset", {29'd0, in_ready}, 32'd7);
    $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure with in_valid held high, then back-to-back accept (DIGIT=4 instance).
    out_ready = 1'b0;
    a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h8000; b = 16'h0001; bin = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp out_valid", {31'd0, out_valid[0]}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold d c%0d", c), {16'd0, d_o[0]}, 32'h1000);
      chk($sformatf("bp hold flags c%0d", c), {29'd0, out_valid[0], bout[0], zero[0]}, 32'd4);
      chk($sformatf("bp in_ready c%0d", c), {31'd0, in_ready[0]}, 32'd0);
    end
    $display("backpressure: d=%h held, in_ready=%b", d_o[0], in_ready[0]);
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b consumed", {31'd0, out_valid[0]}, 32'd0);
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid[0]) break;
      @(posedge clk); #1;
      cyc = c;
    end
    chk("b2b latency", cyc, 32'd4);
    chk("b2b d", {16'd0, d_o[0]}, 32'h7FFF);
    chk("b2b ovf", {31'd0, ovf[0]}, 32'd1);
    $display("back-to-back: second d=%h ovf=%b after %0d cycles", d_o[0], ovf[0], cyc);
    repeat (20) @(posedge clk);
    #1;

    // Asynchronous reset in the second RUN cycle.
    a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst mid-run out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("rst mid-run d", {16'd0, d_o[0]}, 32'd0);
    chk("rst mid-run in_ready", {31'd0, in_ready[0]}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready after mid-run reset", {29'd0, in_ready}, 32'd7);
    chk("no partial result", {29'd0, out_valid}, 32'd0);
    $display("mid-run reset: out_valid=%b d=%h in_ready=%b", out_valid, d_o[0], in_ready);
    run_vec(vecs[2], 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_subtractor.md
Name: digit_serial_subtractor

Overview:
Parametrised N-bit subtractor computing d = a - b - bin. It processes DIGIT bits per clock and carries the borrow forward in a register between cycles, trading latency for area against the fixed 4-bit ripple subtractor. Operands enter through a valid/ready handshake. The result leaves with borrow, signed-overflow and zero flags through a second valid/ready handshake. The block sits in the ALU datapath wherever a wide subtract is needed and single-cycle ripple timing is not acceptable.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT and at least 2*DIGIT
DIGIT, 4, bits processed per cycle; legal values are 1, 2, 4 and 8

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operands a, b, bin are valid
in_ready  out  1  block can accept operands this cycle
a  in  WIDTH  minuend
b  in  WIDTH  subtrahend
bin  in  1  borrow-in
out_valid  out  1  result and flags are valid
out_ready  in  1  consumer accepts the result
d  out  WIDTH  difference
bout  out  1  unsigned borrow-out (a < b + bin)
ovf  out  1  two's-complement overflow
zero  out  1  d == 0

Behaviour:
- Constant NUM_DIGITS = WIDTH/DIGIT. The digit counter is clog2(NUM_DIGITS) bits wide.
- State machine has three states: IDLE, RUN, DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE; digit counter = 0; borrow register = 0.
  - d = 0, bout = 0, ovf = 0, zero = 0, out_valid = 0.
  - in_ready is 1 in the first cycle after reset deasserts.
  - Any operation in flight is discarded. No partial result is ever presented.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This is combinational from state and out_ready.
- Accept = in_valid && in_ready. On accept:
  - latch a and b into shift registers;
  - load the borrow register with bin;
  - clear the counter and the result register;
  - go to RUN.
- RUN, each cycle:
  - Subtract the low DIGIT bits of the a and b shift registers with the registered borrow.
  - Shift the DIGIT-bit difference into the top of the result register; shift the operand registers right by DIGIT.
  - Register the slice borrow-out as the new borrow.
  - Increment the counter.
- RUN exit: the cycle that processes digit NUM_DIGITS-1 transitions to DONE.
  - Latency from the accept edge to out_valid high is exactly NUM_DIGITS cycles (4 for the defaults).
- DONE:
  - out_valid = 1.
  - d holds the full difference; bout holds the final borrow.
  - ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), computed from the latched original operand MSBs. bin does not change the ovf rule.
  - zero = (d == 0).
- Backpressure: while out_valid && !out_ready, d, bout, ovf and zero are held stable and no new operands are accepted.
- out_valid && out_ready:
  - Result is consumed.
  - If in_valid is also high in the same cycle, the new operands are accepted and the state goes to RUN. This is back-to-back operation with no bubble.
  - Otherwise the state goes to IDLE.
- Outputs d and the flags keep their last values in IDLE. Only out_valid qualifies them.
- in_valid asserted during RUN is ignored (in_ready = 0). Operands on a, b and bin are sampled only on accept, so they may change freely afterwards.
- Arithmetic is modulo 2^WIDTH. bout = 1 exactly when a < b + bin, taking the unsigned values.

Decomposition:
- Shared ALU package/header holds:
  - the state encoding constants (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - the NUM_DIGITS derivation;
  - a clog2 helper function.
- One sub-module, sub_digit: a combinational DIGIT-bit borrow-ripple subtractor slice, parameter DIGIT, ports a, b, bin, d, bout. It is instantiated once and reused each cycle.
- The top module holds the FSM, counter, shift registers and flag logic.

Test Plan:
All scenarios use WIDTH=16, DIGIT=4 unless stated.
1. a=0x1234, b=0x0234, bin=0, out_ready=1 -> out_valid high exactly 4 cycles after accept; d=0x1000, bout=0, ovf=0, zero=0.
2. a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0. Then a=0x8000, b=0x0001 -> d=0x7FFF, bout=0, ovf=1.
3. a=0x0005, b=0x0005, bin=1 -> d=0xFFFF, bout=1, zero=0. Then a=b=0xABCD, bin=0 -> d=0x0000, bout=0, zero=1.
4. Hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> d and the flags are stable and in_ready=0 throughout. Raise out_ready with in_valid=1 -> the result is consumed and new operands are accepted in the same cycle; the second result appears 4 cycles later.
5. Assert rst asynchronously in the 2nd RUN cycle -> d=0, out_valid=0 and state IDLE immediately. in_ready=1 after release, and the next operation returns a correct result.
6. Rerun scenarios 1-3 with DIGIT=1 (latency 16) and DIGIT=8 (latency 2) -> identical d and flags.
